// File: rtl/fifo_pkg.sv
// State encoding and counter sizing shared by the async-FIFO flush controller.
// No logic here; latency/backpressure are properties of the modules that import it.
package fifo_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    IDLE        = 3'd0,
    DRAIN       = 3'd1,
    CLEAR       = 3'd2,
    WAIT_REMOTE = 3'd3,
    DONE        = 3'd4,
    ERR         = 3'd5
  } flush_state_t;

  // One spare bit so a counter can hold the limit value itself without wrapping.
  function automatic int cnt_width(input int limit);
    return $clog2(limit) + 1;
  endfunction

endpackage

// File: rtl/fifo_flush_ctrl_if.sv
// Flush request/status bundle between a FIFO side and its flush controller.
// master drives requests and observed FIFO state; slave (the controller) drives stall/clear/status.
interface fifo_flush_ctrl_if #(
  parameter int ADDRSIZE = 5
);
  logic                flush_req;
  logic                local_busy;
  logic [ADDRSIZE:0]   ptr_sync;
  logic                err_clr;
  logic                inc_block;
  logic                ptr_clear;
  logic                flush_busy;
  logic                flush_done;
  logic                flush_err;

  modport master (
    output flush_req, local_busy, ptr_sync, err_clr,
    input  inc_block, ptr_clear, flush_busy, flush_done, flush_err
  );

  modport slave (
    input  flush_req, local_busy, ptr_sync, err_clr,
    output inc_block, ptr_clear, flush_busy, flush_done, flush_err
  );
endinterface

// File: rtl/flush_timer.sv
// Saturating up-counter with sync clear/enable; tc is high once LIMIT-1 is reached and stays.
// tc is combinational from the count register; no handshake, enable simply stalls the count.
module flush_timer
  import fifo_pkg::*;
#(
  parameter int LIMIT = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);
  localparam int W = cnt_width(LIMIT);

  logic [W-1:0] cnt;

  assign tc = (cnt == W'(LIMIT - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && !tc) begin
      cnt <= cnt + W'(1);
    end
  end
endmodule

// File: rtl/fifo_flush_ctrl.sv
// Flush sequencer for one async-FIFO side: stall, clear pointers, await stable zero remote pointer.
// Outputs registered from next state (1-cycle); DRAIN waits on local_busy, WAIT_REMOTE bounded by TIMEOUT.
module fifo_flush_ctrl
  import fifo_pkg::*;
#(
  parameter int ADDRSIZE    = 5,
  parameter int CLR_CYCLES  = 2,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 64
) (
  input  logic               clk,
  input  logic               rst,
  fifo_flush_ctrl_if.slave   bus
);
  localparam int PW = ADDRSIZE + 1;
  localparam int ZW = cnt_width(SYNC_STAGES);

  flush_state_t  state, state_nxt;
  logic [ZW-1:0] zcnt;
  logic [PW-1:0] remote_ptr;
  logic          zero_smp, zero_done;
  logic          clr_tc, to_tc;
  logic          busy_nxt, clr_nxt, done_nxt, err_nxt;

  // Whole-word compare: works for binary and Gray pointers alike.
  assign remote_ptr = bus.ptr_sync;
  assign zero_smp   = (remote_ptr == '0);
  assign zero_done  = zero_smp && (zcnt == ZW'(SYNC_STAGES - 1));

  flush_timer #(.LIMIT(CLR_CYCLES)) u_clr_timer (
    .clk (clk),
    .rst (rst),
    .clr (state != CLEAR),
    .en  (state == CLEAR),
    .tc  (clr_tc)
  );

  flush_timer #(.LIMIT(TIMEOUT)) u_to_timer (
    .clk (clk),
    .rst (rst),
    .clr (state != WAIT_REMOTE),
    .en  (state == WAIT_REMOTE),
    .tc  (to_tc)
  );

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:        if (bus.flush_req) state_nxt = DRAIN;
      DRAIN:       if (!bus.local_busy) state_nxt = CLEAR;
      CLEAR:       if (clr_tc) state_nxt = WAIT_REMOTE;
      // Completion is checked first so a zero run ending on the last allowed cycle still succeeds.
      WAIT_REMOTE: if (zero_done) state_nxt = DONE;
                   else if (to_tc) state_nxt = ERR;
      DONE:        state_nxt = IDLE;
      ERR:         if (bus.err_clr) state_nxt = IDLE;
                   else if (bus.flush_req) state_nxt = DRAIN;
      default:     state_nxt = IDLE;
    endcase

    busy_nxt = state_nxt inside {DRAIN, CLEAR, WAIT_REMOTE, DONE};
    clr_nxt  = (state_nxt == CLEAR);
    done_nxt = (state_nxt == DONE);
    err_nxt  = (state_nxt == ERR);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= IDLE;
      zcnt           <= '0;
      bus.inc_block  <= 1'b0;
      bus.ptr_clear  <= 1'b0;
      bus.flush_busy <= 1'b0;
      bus.flush_done <= 1'b0;
      bus.flush_err  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state != WAIT_REMOTE || !zero_smp) begin
        zcnt <= '0;
      end else if (zcnt != ZW'(SYNC_STAGES)) begin
        zcnt <= zcnt + ZW'(1);
      end
      bus.inc_block  <= busy_nxt;
      bus.ptr_clear  <= clr_nxt;
      bus.flush_busy <= busy_nxt;
      bus.flush_done <= done_nxt;
      bus.flush_err  <= err_nxt;
    end
  end
endmodule
